// File: rtl/pps_source_ctrl.sv
// PPS source supervisor: measures the external PPS period, selects internal vs external
// PPS for the core, and owns the core's holdoff register (power-up default plus software writes).
module pps_source_ctrl #(
  parameter int unsigned NOMINAL_PERIOD  = 125000000,
  parameter int unsigned TOLERANCE       = 1000,
  parameter int unsigned LOCK_COUNT      = 3,
  parameter int unsigned DEFAULT_HOLDOFF = 10
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        ext_pps_i,
  input  logic [1:0]  mode_i,
  input  logic [7:0]  holdoff_i,
  input  logic        holdoff_wr_i,
  output logic        int_sel_o,
  output logic [7:0]  holdoff_o,
  output logic        holdoff_wr_o,
  output logic        locked_o,
  output logic [1:0]  state_o,
  output logic [31:0] period_o,
  output logic        period_valid_o,
  output logic [15:0] failover_count_o
);

  typedef enum logic [1:0] {HUNT = 2'd0, LOCKED = 2'd1, HOLDOVER = 2'd2} state_t;

  localparam logic [31:0] PERIOD_HI = 32'(NOMINAL_PERIOD + TOLERANCE);
  localparam logic [31:0] PERIOD_LO = 32'(NOMINAL_PERIOD - TOLERANCE);
  localparam logic [3:0]  LOCK_N    = 4'(LOCK_COUNT);
  localparam logic [7:0]  HOLD_DEF  = 8'(DEFAULT_HOLDOFF);

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  (* ASYNC_REG = "TRUE" *) logic sync1_q;
  (* ASYNC_REG = "TRUE" *) logic sync2_q;
  logic        sync3_q;
  logic [31:0] cnt_q;
  logic        seen_q;
  logic        timed_out_q;
  logic [31:0] period_q;
  logic        period_vld_q;
  logic [3:0]  good_q, good_d;
  state_t      state_q, state_d;
  logic        int_sel_q, int_sel_d;
  logic [15:0] fail_q, fail_d;
  logic [7:0]  holdoff_q;
  logic        hwr_q;
  logic        por_q;

  logic        pps_edge, meas, in_range, timeout, good_ev, bad_ev;
  logic [31:0] period_new;

  assign pps_edge   = sync2_q & ~sync3_q;
  assign meas       = pps_edge & seen_q;
  assign period_new = sat_inc32(cnt_q);
  assign in_range   = (period_new >= PERIOD_LO) && (period_new <= PERIOD_HI);
  // An edge landing on the limit cycle is measured as a period instead of timing out.
  assign timeout    = ~pps_edge & ~timed_out_q & (cnt_q == PERIOD_HI);
  assign good_ev    = meas & in_range;
  assign bad_ev     = (meas & ~in_range) | timeout;

  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    fail_d  = fail_q;
    case (state_q)
      LOCKED: begin
        if (bad_ev) begin
          state_d = HOLDOVER;
          fail_d  = sat_inc16(fail_q);
        end
      end
      default: begin
        if (good_ev) begin
          if (good_q + 4'd1 == LOCK_N) begin
            state_d = LOCKED;
            good_d  = 4'd0;
          end else begin
            good_d = good_q + 4'd1;
          end
        end else if (bad_ev) begin
          good_d = 4'd0;
        end
      end
    endcase

    case (mode_i)
      2'd2:    int_sel_d = 1'b1;
      2'd1:    int_sel_d = 1'b0;
      default: int_sel_d = (state_d != LOCKED);
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      sync3_q      <= 1'b0;
      cnt_q        <= 32'd0;
      seen_q       <= 1'b0;
      timed_out_q  <= 1'b0;
      period_q     <= 32'd0;
      period_vld_q <= 1'b0;
      good_q       <= 4'd0;
      state_q      <= HUNT;
      int_sel_q    <= 1'b1;
      fail_q       <= 16'd0;
      holdoff_q    <= HOLD_DEF;
      hwr_q        <= 1'b0;
      por_q        <= 1'b1;
    end else begin
      sync1_q      <= ext_pps_i;
      sync2_q      <= sync1_q;
      sync3_q      <= sync2_q;
      cnt_q        <= pps_edge ? 32'd0 : sat_inc32(cnt_q);
      seen_q       <= seen_q | pps_edge;
      timed_out_q  <= pps_edge ? 1'b0 : (timed_out_q | timeout);
      if (meas) period_q <= period_new;
      period_vld_q <= meas;
      good_q       <= good_d;
      state_q      <= state_d;
      int_sel_q    <= int_sel_d;
      fail_q       <= fail_d;
      // Power-up write and a coincident software write merge into one pulse.
      hwr_q        <= por_q | holdoff_wr_i;
      por_q        <= 1'b0;
      if (holdoff_wr_i) holdoff_q <= holdoff_i;
    end
  end

  assign int_sel_o        = int_sel_q;
  assign holdoff_o        = holdoff_q;
  assign holdoff_wr_o     = hwr_q;
  assign locked_o         = (state_q == LOCKED);
  assign state_o          = state_q;
  assign period_o         = period_q;
  assign period_valid_o   = period_vld_q;
  assign failover_count_o = fail_q;

endmodule

// File: tb/tb_pps_source_ctrl.sv
// Directed bench for pps_source_ctrl with NOMINAL_PERIOD=1000, TOLERANCE=10, LOCK_COUNT=3.
module tb_pps_source_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ext_pps = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [7:0]  hold_in = 8'd0;
  logic        hold_wr = 1'b0;
  logic        int_sel_o, holdoff_wr_o, locked_o, period_valid_o;
  logic [7:0]  holdoff_o;
  logic [1:0]  state_o;
  logic [31:0] period_o;
  logic [15:0] failover_count_o;

  int n_vec = 0;
  int n_err = 0;

  pps_source_ctrl #(.NOMINAL_PERIOD(1000), .TOLERANCE(10), .LOCK_COUNT(3), .DEFAULT_HOLDOFF(10)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .ext_pps_i(ext_pps), .mode_i(mode),
    .holdoff_i(hold_in), .holdoff_wr_i(hold_wr), .int_sel_o(int_sel_o),
    .holdoff_o(holdoff_o), .holdoff_wr_o(holdoff_wr_o), .locked_o(locked_o),
    .state_o(state_o), .period_o(period_o), .period_valid_o(period_valid_o),
    .failover_count_o(failover_count_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    ext_pps = 1'b0;
    repeat (n) tick();
  endtask

  // Rising edge on ext_pps; returns once the resulting edge has been registered.
  task automatic rise3();
    ext_pps = 1'b1;
    repeat (3) tick();
  endtask

  // Full period of n cycles ending with the edge registered.
  task automatic per(input int n);
    idle(n - 3);
    rise3();
  endtask

  task automatic do_reset();
    ext_pps = 1'b0;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    ext_pps = 1'b0;
    rst_n = 1'b0;
    tick();
    n_vec++; if (holdoff_o !== 8'd10) begin n_err++; $display("FAIL rst_holdoff: got %0d want 10", holdoff_o); end
    n_vec++; if (int_sel_o !== 1'b1) begin n_err++; $display("FAIL rst_int_sel: got %0b want 1", int_sel_o); end
    n_vec++; if (state_o !== 2'd0) begin n_err++; $display("FAIL rst_state: got %0d want 0", state_o); end
    n_vec++; if (holdoff_wr_o !== 1'b0) begin n_err++; $display("FAIL rst_wr: got %0b want 0", holdoff_wr_o); end
    n_vec++; if (period_o !== 32'd0 || failover_count_o !== 16'd0) begin n_err++; $display("FAIL rst_counts: got period %0d fail %0d want 0 0", period_o, failover_count_o); end
    rst_n = 1'b1;
    tick();
    n_vec++; if (holdoff_wr_o !== 1'b1 || holdoff_o !== 8'd10) begin n_err++; $display("FAIL por_write: got wr %0b val %0d want 1 10", holdoff_wr_o, holdoff_o); end
    tick();
    n_vec++; if (holdoff_wr_o !== 1'b0) begin n_err++; $display("FAIL por_single: got wr %0b want 0", holdoff_wr_o); end
    n_vec++; if (int_sel_o !== 1'b1 || state_o !== 2'd0) begin n_err++; $display("FAIL por_state: got sel %0b state %0d want 1 0", int_sel_o, state_o); end
  endtask

  task automatic test_lock();
    rise3();
    n_vec++; if (period_valid_o !== 1'b0) begin n_err++; $display("FAIL first_edge_valid: got %0b want 0", period_valid_o); end
    per(1000);
    n_vec++; if (period_valid_o !== 1'b1 || period_o !== 32'd1000) begin n_err++; $display("FAIL period1: got vld %0b per %0d want 1 1000", period_valid_o, period_o); end
    tick();
    n_vec++; if (period_valid_o !== 1'b0) begin n_err++; $display("FAIL valid_pulse: got %0b want 0", period_valid_o); end
    idle(996);
    rise3();
    idle(997);
    ext_pps = 1'b1;
    tick(); tick();
    n_vec++; if (state_o !== 2'd0) begin n_err++; $display("FAIL prelock_state: got %0d want 0", state_o); end
    tick();
    n_vec++; if (state_o !== 2'd1 || int_sel_o !== 1'b0 || locked_o !== 1'b1) begin n_err++; $display("FAIL lock: got state %0d sel %0b lk %0b want 1 0 1", state_o, int_sel_o, locked_o); end
    n_vec++; if (period_o !== 32'd1000) begin n_err++; $display("FAIL lock_period: got %0d want 1000", period_o); end
    // Mode override within the next gap
    ext_pps = 1'b0;
    mode = 2'd2;
    tick();
    n_vec++; if (int_sel_o !== 1'b1 || locked_o !== 1'b1) begin n_err++; $display("FAIL force_int: got sel %0b lk %0b want 1 1", int_sel_o, locked_o); end
    mode = 2'd0;
    tick();
    n_vec++; if (int_sel_o !== 1'b0) begin n_err++; $display("FAIL auto_back: got sel %0b want 0", int_sel_o); end
    idle(995);
    rise3();
    n_vec++; if (state_o !== 2'd1) begin n_err++; $display("FAIL stay_locked: got %0d want 1", state_o); end
  endtask

  task automatic test_missing();
    idle(1010);
    n_vec++; if (state_o !== 2'd1) begin n_err++; $display("FAIL pre_timeout: got %0d want 1", state_o); end
    tick();
    n_vec++; if (state_o !== 2'd2 || int_sel_o !== 1'b1 || failover_count_o !== 16'd1 || locked_o !== 1'b0) begin n_err++; $display("FAIL timeout: got state %0d sel %0b fail %0d lk %0b want 2 1 1 0", state_o, int_sel_o, failover_count_o, locked_o); end
    rise3();
    n_vec++; if (period_o !== 32'd1014 || state_o !== 2'd2) begin n_err++; $display("FAIL gap_edge: got per %0d state %0d want 1014 2", period_o, state_o); end
    per(1000);
    per(1000);
    n_vec++; if (state_o !== 2'd2) begin n_err++; $display("FAIL relock_early: got %0d want 2", state_o); end
    per(1000);
    n_vec++; if (state_o !== 2'd1 || int_sel_o !== 1'b0 || failover_count_o !== 16'd1) begin n_err++; $display("FAIL relock: got state %0d sel %0b fail %0d want 1 0 1", state_o, int_sel_o, failover_count_o); end
  endtask

  task automatic test_offfreq();
    per(1011);
    n_vec++; if (period_o !== 32'd1011 || state_o !== 2'd2 || failover_count_o !== 16'd2 || int_sel_o !== 1'b1) begin n_err++; $display("FAIL off_freq: got per %0d state %0d fail %0d sel %0b want 1011 2 2 1", period_o, state_o, failover_count_o, int_sel_o); end
  endtask

  task automatic test_hunt_restart();
    do_reset();
    tick();
    rise3();
    per(1000);
    per(1000);
    per(989);
    n_vec++; if (period_o !== 32'd989 || state_o !== 2'd0) begin n_err++; $display("FAIL bad_989: got per %0d state %0d want 989 0", period_o, state_o); end
    per(1000);
    per(1000);
    n_vec++; if (state_o !== 2'd0) begin n_err++; $display("FAIL good_restart: got %0d want 0", state_o); end
    per(1000);
    n_vec++; if (state_o !== 2'd1 || failover_count_o !== 16'd0) begin n_err++; $display("FAIL hunt_lock: got state %0d fail %0d want 1 0", state_o, failover_count_o); end
  endtask

  task automatic test_boundary();
    do_reset();
    tick();
    rise3();
    per(990);
    per(1010);
    n_vec++; if (period_o !== 32'd1010 || state_o !== 2'd0) begin n_err++; $display("FAIL edge_1010: got per %0d state %0d want 1010 0", period_o, state_o); end
    per(990);
    n_vec++; if (period_o !== 32'd990 || state_o !== 2'd1) begin n_err++; $display("FAIL edge_990_lock: got per %0d state %0d want 990 1", period_o, state_o); end
  endtask

  task automatic test_force_ext();
    do_reset();
    mode = 2'd1;
    tick();
    n_vec++; if (int_sel_o !== 1'b0 || state_o !== 2'd0) begin n_err++; $display("FAIL force_ext: got sel %0b state %0d want 0 0", int_sel_o, state_o); end
    rise3();
    per(1000);
    per(1000);
    per(1000);
    n_vec++; if (state_o !== 2'd1 || locked_o !== 1'b1 || int_sel_o !== 1'b0) begin n_err++; $display("FAIL force_ext_lock: got state %0d lk %0b sel %0b want 1 1 0", state_o, locked_o, int_sel_o); end
    mode = 2'd0;
    idle(1);
  endtask

  task automatic test_holdoff();
    hold_in = 8'h55; hold_wr = 1'b1;
    tick();
    hold_wr = 1'b0;
    n_vec++; if (holdoff_wr_o !== 1'b1 || holdoff_o !== 8'h55) begin n_err++; $display("FAIL sw_write: got wr %0b val %0h want 1 55", holdoff_wr_o, holdoff_o); end
    tick();
    n_vec++; if (holdoff_wr_o !== 1'b0 || holdoff_o !== 8'h55) begin n_err++; $display("FAIL sw_single: got wr %0b val %0h want 0 55", holdoff_wr_o, holdoff_o); end
    hold_in = 8'hA1; hold_wr = 1'b1;
    tick();
    hold_in = 8'hB2;
    n_vec++; if (holdoff_wr_o !== 1'b1 || holdoff_o !== 8'hA1) begin n_err++; $display("FAIL b2b_1: got wr %0b val %0h want 1 a1", holdoff_wr_o, holdoff_o); end
    tick();
    hold_wr = 1'b0;
    n_vec++; if (holdoff_wr_o !== 1'b1 || holdoff_o !== 8'hB2) begin n_err++; $display("FAIL b2b_2: got wr %0b val %0h want 1 b2", holdoff_wr_o, holdoff_o); end
    tick();
    n_vec++; if (holdoff_wr_o !== 1'b0) begin n_err++; $display("FAIL b2b_end: got wr %0b want 0", holdoff_wr_o); end
    // Software write coincident with the power-up write
    ext_pps = 1'b0;
    rst_n = 1'b0;
    tick();
    hold_in = 8'h55; hold_wr = 1'b1;
    rst_n = 1'b1;
    tick();
    hold_wr = 1'b0;
    n_vec++; if (holdoff_wr_o !== 1'b1 || holdoff_o !== 8'h55) begin n_err++; $display("FAIL release_write: got wr %0b val %0h want 1 55", holdoff_wr_o, holdoff_o); end
    tick();
    n_vec++; if (holdoff_wr_o !== 1'b0 || holdoff_o !== 8'h55) begin n_err++; $display("FAIL release_single: got wr %0b val %0h want 0 55", holdoff_wr_o, holdoff_o); end
  endtask

  task automatic test_async_reset();
    rise3();
    per(1000);
    per(1000);
    per(1000);
    idle(1011);
    n_vec++; if (state_o !== 2'd2 || failover_count_o !== 16'd1) begin n_err++; $display("FAIL pre_async: got state %0d fail %0d want 2 1", state_o, failover_count_o); end
    idle(100);
    #2;
    rst_n = 1'b0;
    #1;
    n_vec++; if (state_o !== 2'd0 || int_sel_o !== 1'b1 || locked_o !== 1'b0 || holdoff_o !== 8'd10) begin n_err++; $display("FAIL async_ctrl: got state %0d sel %0b lk %0b hold %0d want 0 1 0 10", state_o, int_sel_o, locked_o, holdoff_o); end
    n_vec++; if (period_o !== 32'd0 || failover_count_o !== 16'd0 || period_valid_o !== 1'b0 || holdoff_wr_o !== 1'b0) begin n_err++; $display("FAIL async_data: got per %0d fail %0d vld %0b wr %0b want 0 0 0 0", period_o, failover_count_o, period_valid_o, holdoff_wr_o); end
    #2;
    rst_n = 1'b1;
    tick();
    n_vec++; if (holdoff_wr_o !== 1'b1 || holdoff_o !== 8'd10) begin n_err++; $display("FAIL repor: got wr %0b val %0d want 1 10", holdoff_wr_o, holdoff_o); end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_missing();
    test_offfreq();
    test_hunt_restart();
    test_boundary();
    test_force_ext();
    test_holdoff();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
